// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick prescaler, H/V counters, programmable sync/porch
// geometry and a tick-enabled pipeline that aligns sync/blank with slow pixel sources.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_LAT  = 1,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    r,
    input  logic [7:0]    g,
    input  logic [7:0]    b,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pix_req,
    output logic          frame_start,
    output logic          line_start,
    output logic [28:0]   vga_output_data
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    // One extra bit keeps the sync-end bounds representable when a back porch is zero.
    localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [27:0] BUS_RESET = {1'b1, 1'b0, ~VS_POL, ~HS_POL, 24'h0};

    logic [DW-1:0] divCnt_q, divCnt_d;
    logic          tick;
    logic [CW-1:0] hCnt_q, hCnt_d;
    logic [CW-1:0] vCnt_q, vCnt_d;
    logic          hAct, vAct, hSync, vSync;
    logic [3:0]    decode;
    logic [3:0]    tail;
    logic [27:0]   bus_q, bus_d;
    logic          pixClk_q;
    logic          frameStart_q;
    logic          lineStart_q;
    logic          pixReq_q;

    always_comb begin
        tick     = (divCnt_q == DIV_LAST);
        divCnt_d = tick ? '0 : divCnt_q + 1'b1;
        hCnt_d   = hCnt_q;
        vCnt_d   = vCnt_q;
        if (tick) begin
            if (hCnt_q == H_LAST) begin
                hCnt_d = '0;
                vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;
            end else begin
                hCnt_d = hCnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        hAct   = ({1'b0, hCnt_q} < H_ACT_END);
        vAct   = ({1'b0, vCnt_q} < V_ACT_END);
        hSync  = ({1'b0, hCnt_q} >= H_SYNC_BEG) && ({1'b0, hCnt_q} < H_SYNC_END);
        vSync  = ({1'b0, vCnt_q} >= V_SYNC_BEG) && ({1'b0, vCnt_q} < V_SYNC_END);
        decode = {hAct, vAct, hSync, vSync};
    end

    // Delay the decoded position by the pixel source's latency so all bus fields move together.
    generate
        if (PIX_LAT == 0) begin : g_noPipe
            assign tail = decode;
        end else begin : g_pipe
            logic [3:0] pipe_q [PIX_LAT];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < PIX_LAT; i++) pipe_q[i] <= 4'b0;
                end else if (tick) begin
                    pipe_q[0] <= decode;
                    for (int i = 1; i < PIX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign tail = pipe_q[PIX_LAT-1];
        end
    endgenerate

    always_comb begin
        bus_d = bus_q;
        if (tick) begin
            bus_d[23:0] = (tail[3] & tail[2]) ? {b, g, r} : 24'h0;
            bus_d[24]   = tail[1] ~^ HS_POL;
            bus_d[25]   = tail[0] ~^ VS_POL;
            bus_d[26]   = tail[3] & tail[2];
            bus_d[27]   = ~(tail[1] | tail[0]);
        end
    end

    // Pixel clock tracks the prescaler phase so its rising edge lands mid-way through each pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCnt_q     <= '0;
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            bus_q        <= BUS_RESET;
            pixClk_q     <= 1'b0;
            frameStart_q <= 1'b0;
            lineStart_q  <= 1'b0;
            pixReq_q     <= 1'b0;
        end else begin
            divCnt_q     <= divCnt_d;
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            bus_q        <= bus_d;
            pixClk_q     <= (divCnt_d >= DIV_HALF);
            frameStart_q <= tick && (hCnt_q == '0) && (vCnt_q == '0);
            lineStart_q  <= tick && (hCnt_q == '0);
            pixReq_q     <= ({1'b0, hCnt_d} < H_ACT_END) && ({1'b0, vCnt_d} < V_ACT_END);
        end
    end

    assign x               = hCnt_q;
    assign y               = vCnt_q;
    assign pix_req         = pixReq_q;
    assign frame_start     = frameStart_q;
    assign line_start      = lineStart_q;
    assign vga_output_data = {pixClk_q, bus_q};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, latency-2, tiny geometry) checked every
// clock against an arithmetic model of position, strobes and the DAC bus.
module tb_vga_timing_gen;

    typedef struct {
        int          x;
        int          y;
        logic        pixReq;
        logic        fs;
        logic        ls;
        logic [28:0] bus;
    } expT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
    logic [9:0]  x0, y0, x1, y1;
    logic [3:0]  x2, y2;
    logic        pr0, fs0, ls0, pr1, fs1, ls1, pr2, fs2, ls2;
    logic [28:0] vga0, vga1, vga2;
    logic [23:0] cap0, cap2;
    logic [7:0]  src1a, src1b;
    int          cyc;
    int          nPass = 0;
    int          nChecks = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut0 (
        .clk(clk), .rst(rst), .r(r0), .g(g0), .b(b0), .x(x0), .y(y0),
        .pix_req(pr0), .frame_start(fs0), .line_start(ls0), .vga_output_data(vga0)
    );

    vga_timing_gen #(.PIX_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .r(r1), .g(g1), .b(b1), .x(x1), .y(y1),
        .pix_req(pr1), .frame_start(fs1), .line_start(ls1), .vga_output_data(vga1)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(1), .CW(4)
    ) dut2 (
        .clk(clk), .rst(rst), .r(r2), .g(g2), .b(b2), .x(x2), .y(y2),
        .pix_req(pr2), .frame_start(fs2), .line_start(ls2), .vga_output_data(vga2)
    );

    // Clock edges since reset release; every expectation is derived from this count.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Colour present at each pixel-tick edge, i.e. what the output register should latch.
    always @(posedge clk) begin
        if (rst && ((cyc + 1) % 2 == 0)) cap0 <= {b0, g0, r0};
        if (rst && ((cyc + 1) % 4 == 0)) cap2 <= {b2, g2, r2};
    end

    // Pixel source with a two-tick answer delay: r is the low byte of the requested x.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            src1a <= 8'h0;
            src1b <= 8'h0;
        end else if ((cyc + 1) % 2 == 0) begin
            src1a <= x1[7:0];
            src1b <= src1a;
        end
    end
    assign r1 = src1b;

    initial begin
        g1 = 8'h3C;
        b1 = 8'hA5;
        forever begin
            @(negedge clk);
            r0 = 8'($urandom); g0 = 8'($urandom); b0 = 8'($urandom);
            r2 = 8'($urandom); g2 = 8'($urandom); b2 = 8'($urandom);
        end
    end

    function automatic expT model(int c, int cd, int ha, int hf, int hsw, int hb,
                                  int va, int vf, int vsw, int vb, int lat,
                                  logic hp, logic vp, logic [23:0] rgb);
        expT  e;
        int   ht = ha + hf + hsw + hb;
        int   vt = va + vf + vsw + vb;
        int   k = c / cd;
        int   p = k - 1 - lat;
        int   ph, pv;
        logic tickEdge;
        logic act = 1'b0;
        logic hsA = 1'b0;
        logic vsA = 1'b0;
        e.x      = k % ht;
        e.y      = (k / ht) % vt;
        e.pixReq = (c >= 1) && (e.x < ha) && (e.y < va);
        tickEdge = (c > 0) && (c % cd == 0);
        e.ls     = tickEdge && ((k - 1) % ht == 0);
        e.fs     = tickEdge && ((k - 1) % (ht * vt) == 0);
        if (p >= 0) begin
            ph  = p % ht;
            pv  = (p / ht) % vt;
            act = (ph < ha) && (pv < va);
            hsA = (ph >= ha + hf) && (ph < ha + hf + hsw);
            vsA = (pv >= va + vf) && (pv < va + vf + vsw);
        end
        e.bus = {((c % cd) >= cd / 2), ~(hsA | vsA), act, (vsA ? vp : ~vp),
                 (hsA ? hp : ~hp), (act ? rgb : 24'h0)};
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++; if (vga0 !== 29'h0B00_0000) $display("[TB] FAIL reset_bus0 got %h want %h", vga0, 29'h0B00_0000); else nPass++;
        nChecks++; if (vga1 !== 29'h0B00_0000) $display("[TB] FAIL reset_bus1 got %h want %h", vga1, 29'h0B00_0000); else nPass++;
        nChecks++; if (vga2 !== 29'h0800_0000) $display("[TB] FAIL reset_bus2 got %h want %h", vga2, 29'h0800_0000); else nPass++;
        nChecks++; if ({x0, y0, x2, y2} !== 28'h0) $display("[TB] FAIL reset_xy got %h want 0", {x0, y0, x2, y2}); else nPass++;
        nChecks++; if ({pr0, fs0, ls0, pr2, fs2, ls2} !== 6'b0) $display("[TB] FAIL reset_strobes got %b want 000000", {pr0, fs0, ls0, pr2, fs2, ls2}); else nPass++;
    endtask

    task automatic test_line_timing();
        expT e;
        int  hsLow = 0;
        int  blankHi = 0;
        int  lastLs = -1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3208; i++) begin
            @(negedge clk);
            e = model(cyc, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0, cap0);
            nChecks++; if (vga0 !== e.bus) $display("[TB] FAIL line_bus c=%0d got %h want %h", cyc, vga0, e.bus); else nPass++;
            nChecks++; if ({x0, y0} !== {10'(e.x), 10'(e.y)}) $display("[TB] FAIL line_xy c=%0d got %0d,%0d want %0d,%0d", cyc, x0, y0, e.x, e.y); else nPass++;
            nChecks++; if ({pr0, fs0, ls0} !== {e.pixReq, e.fs, e.ls}) $display("[TB] FAIL line_strobes c=%0d got %b want %b", cyc, {pr0, fs0, ls0}, {e.pixReq, e.fs, e.ls}); else nPass++;
            if (cyc == 1315 || cyc == 1316) begin
                nChecks++; if (vga0[24] !== (cyc == 1315)) $display("[TB] FAIL hsync_edge c=%0d got %b want %b", cyc, vga0[24], (cyc == 1315)); else nPass++;
            end
            if (cyc > 1604 && cyc <= 3204) begin
                if (vga0[24] === 1'b0) hsLow++;
                if (vga0[26] === 1'b1) blankHi++;
            end
            if (ls0 === 1'b1) begin
                if (lastLs >= 0) begin
                    nChecks++; if (cyc - lastLs != 1600) $display("[TB] FAIL line_period got %0d want 1600", cyc - lastLs); else nPass++;
                end
                lastLs = cyc;
            end
        end
        nChecks++; if (hsLow != 192) $display("[TB] FAIL hsync_width got %0d want 192", hsLow); else nPass++;
        nChecks++; if (blankHi != 1280) $display("[TB] FAIL blank_width got %0d want 1280", blankHi); else nPass++;
        nChecks++; if (lastLs != 3202) $display("[TB] FAIL last_line_start got %0d want 3202", lastLs); else nPass++;
    endtask

    task automatic test_latency();
        expT         e;
        int          p;
        logic [23:0] rgbE;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            p    = cyc / 2 - 3;
            rgbE = {8'hA5, 8'h3C, 8'((p < 0 ? 0 : p) % 800)};
            e    = model(cyc, 2, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0, rgbE);
            nChecks++; if (vga1 !== e.bus) $display("[TB] FAIL lat_bus c=%0d got %h want %h", cyc, vga1, e.bus); else nPass++;
            if (cyc == 5) begin
                nChecks++; if (vga1[26] !== 1'b0) $display("[TB] FAIL lat_pre_blank got %b want 0", vga1[26]); else nPass++;
            end
            if (cyc == 6) begin
                nChecks++; if ({vga1[26], vga1[7:0]} !== 9'h100) $display("[TB] FAIL lat_first_pixel got %h want 100", {vga1[26], vga1[7:0]}); else nPass++;
            end
            if (cyc == 516) begin
                nChecks++; if (vga1[7:0] !== 8'hFF) $display("[TB] FAIL lat_r255 got %h want ff", vga1[7:0]); else nPass++;
            end
            if (cyc == 1286) begin
                nChecks++; if ({vga1[26], vga1[7:0]} !== 9'h000) $display("[TB] FAIL lat_blank_black got %h want 000", {vga1[26], vga1[7:0]}); else nPass++;
            end
        end
    endtask

    task automatic test_small_geometry();
        expT e;
        int  lastFs = -1;
        int  lsCount = 0;
        int  clkHi = 0;
        int  hsHi = 0;
        int  vsHi = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 292; i++) begin
            @(negedge clk);
            e = model(cyc, 4, 4, 1, 1, 1, 2, 1, 1, 1, 1, 1'b1, 1'b1, cap2);
            nChecks++; if (vga2 !== e.bus) $display("[TB] FAIL small_bus c=%0d got %h want %h", cyc, vga2, e.bus); else nPass++;
            nChecks++; if ({x2, y2} !== {4'(e.x), 4'(e.y)}) $display("[TB] FAIL small_xy c=%0d got %0d,%0d want %0d,%0d", cyc, x2, y2, e.x, e.y); else nPass++;
            nChecks++; if ({pr2, fs2, ls2} !== {e.pixReq, e.fs, e.ls}) $display("[TB] FAIL small_strobes c=%0d got %b want %b", cyc, {pr2, fs2, ls2}, {e.pixReq, e.fs, e.ls}); else nPass++;
            if (cyc <= 140 && ls2 === 1'b1) lsCount++;
            if (cyc <= 280 && vga2[28] === 1'b1) clkHi++;
            if (cyc > 8 && cyc <= 148) begin
                if (vga2[24] === 1'b1) hsHi++;
                if (vga2[25] === 1'b1) vsHi++;
            end
            if (fs2 === 1'b1) begin
                if (lastFs >= 0) begin
                    nChecks++; if (cyc - lastFs != 140) $display("[TB] FAIL frame_period got %0d want 140", cyc - lastFs); else nPass++;
                end
                lastFs = cyc;
            end
        end
        nChecks++; if (lsCount != 5) $display("[TB] FAIL lines_per_frame got %0d want 5", lsCount); else nPass++;
        nChecks++; if (clkHi != 140) $display("[TB] FAIL pixclk_duty got %0d want 140", clkHi); else nPass++;
        nChecks++; if (hsHi != 20) $display("[TB] FAIL small_hsync_high got %0d want 20", hsHi); else nPass++;
        nChecks++; if (vsHi != 28) $display("[TB] FAIL small_vsync_high got %0d want 28", vsHi); else nPass++;
        nChecks++; if (lastFs != 284) $display("[TB] FAIL last_frame_start got %0d want 284", lastFs); else nPass++;
    endtask

    task automatic test_mid_reset();
        expT e;
        int  tgt;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tgt = 2 * (1100 + int'($urandom_range(0, 50))) + int'($urandom_range(0, 1));
        while (cyc < tgt) begin
            @(negedge clk);
            e = model(cyc, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0, cap0);
            nChecks++; if (vga0 !== e.bus) $display("[TB] FAIL pre_reset_bus c=%0d got %h want %h", cyc, vga0, e.bus); else nPass++;
            nChecks++; if ({x0, y0} !== {10'(e.x), 10'(e.y)}) $display("[TB] FAIL pre_reset_xy c=%0d got %0d,%0d want %0d,%0d", cyc, x0, y0, e.x, e.y); else nPass++;
        end
        rst = 1'b0;
        #1;
        nChecks++; if (vga0 !== 29'h0B00_0000) $display("[TB] FAIL midrst_bus0 got %h want %h", vga0, 29'h0B00_0000); else nPass++;
        nChecks++; if (vga2 !== 29'h0800_0000) $display("[TB] FAIL midrst_bus2 got %h want %h", vga2, 29'h0800_0000); else nPass++;
        nChecks++; if ({x0, y0, pr0, fs0, ls0} !== 23'h0) $display("[TB] FAIL midrst_outs got %h want 0", {x0, y0, pr0, fs0, ls0}); else nPass++;
        repeat (3) @(negedge clk);
        nChecks++; if (vga0 !== 29'h0B00_0000) $display("[TB] FAIL midrst_hold got %h want %h", vga0, 29'h0B00_0000); else nPass++;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            e = model(cyc, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0, cap0);
            nChecks++; if (vga0 !== e.bus) $display("[TB] FAIL post_reset_bus c=%0d got %h want %h", cyc, vga0, e.bus); else nPass++;
            nChecks++; if ({pr0, fs0, ls0} !== {e.pixReq, e.fs, e.ls}) $display("[TB] FAIL post_reset_strobes c=%0d got %b want %b", cyc, {pr0, fs0, ls0}, {e.pixReq, e.fs, e.ls}); else nPass++;
            if (cyc == 1) begin
                nChecks++; if ({x0, y0} !== 20'h0) $display("[TB] FAIL post_reset_origin got %0d,%0d want 0,0", x0, y0); else nPass++;
            end
            if (cyc == 2) begin
                nChecks++; if ({fs0, ls0} !== 2'b11) $display("[TB] FAIL post_reset_first_tick got %b want 11", {fs0, ls0}); else nPass++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_line_timing();
        test_latency();
        test_small_geometry();
        test_mid_reset();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator that replaces the fixed 640x480 generator. From the system clock it derives a pixel tick, pixel-clock output and H/V counters with programmable porch and sync widths and sync polarity. A configurable latency-compensation pipeline keeps sync and blank aligned with RGB from pixel sources that take several ticks to answer an (x, y) request. It drives the same 29-bit `vga_output_data` bus to the DAC pins.

## Interface

**Parameters**
- `CLK_DIV`, 2: system clocks per pixel tick; must be an even number ≥2.
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`: 640, 16, 96, 48. Horizontal widths in ticks; `H_TOTAL` is their sum.
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`: 480, 10, 2, 33. Vertical widths in lines; `V_TOTAL` is their sum.
- `HS_POL`, `VS_POL`, 0: active level of hsync/vsync (0 means active-low).
- `PIX_LAT`, 1: pixel-source latency in ticks, range 0..4.
- `CW`, 10: counter width; `2^CW` must be ≥ `H_TOTAL` and ≥ `V_TOTAL`.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `r`, `g`, `b` in 8 each: pixel colour from the source.
- `x`, `y` out CW each: current H/V counter values (the pixel request position).
- `pix_req` out 1: high while `x < H_ACTIVE` and `y < V_ACTIVE`.
- `frame_start` out 1: one-clk pulse at the start of a frame.
- `line_start` out 1: one-clk pulse at the start of a line.
- `vga_output_data` out 29. Bit fields:
  - [23:0] = {b,g,r}
  - [24] hsync
  - [25] vsync
  - [26] blank_n
  - [27] sync_n
  - [28] pixel clock

## Operation

**Prescaler**
- `div` counts 0..`CLK_DIV`-1 and wraps.
- `tick` = (`div` == `CLK_DIV`-1).
- Bit [28] is registered and is 1 when `div` ≥ `CLK_DIV`/2. The result is a 50% duty clock whose rising edge falls mid-period of the output data.

**Counters**, advancing only on `tick`
- `h` increments and wraps from `H_TOTAL`-1 to 0.
- `v` increments when `h` wraps, and itself wraps from `V_TOTAL`-1 to 0.
- `x`=`h` and `y`=`v`, both registered.

**Decode**, a combinational function of (`h`,`v`)
- `hact` = `h` < `H_ACTIVE`.
- `hs` = `H_ACTIVE`+`H_FP` ≤ `h` < `H_ACTIVE`+`H_FP`+`H_SYNC`.
- `vact` and `vs` are decoded the same way from `v`.

**Alignment pipeline**
- {`hact`, `vact`, `hs`, `vs`} pass through `PIX_LAT` tick-enabled stages.
- With `PIX_LAT`=0 the pipeline is a wire.

**Output register**, loaded on `tick` from the pipeline tail and the `r`/`g`/`b` inputs
- [23:0] = {b,g,r} when both delayed `hact` and `vact` are set; otherwise 0. Colour is forced black in blanking.
- [24] = `hs_d` XNOR `HS_POL`, giving the active level during sync.
- [25] = `vs_d` XNOR `VS_POL`.
- [26] = `hact_d` & `vact_d`.
- [27] = ~(`hs_d` | `vs_d`), which is always active-low.

**Strobes**
- `frame_start` = `tick` & (`h`,`v`) == (0,0), registered, so it is high for one clk.
- `line_start` = `tick` & `h` == 0, registered in the same way.

**Reset** (asynchronous, while `rst`=0)
- `div`, `h`, `v`, `x`, `y` and all pipeline stages are 0.
- `vga_output_data` [23:0] = 0.
- [24] = ~`HS_POL` and [25] = ~`VS_POL` (the inactive levels).
- [26] = 0, [27] = 1, [28] = 0.
- `pix_req`, `frame_start` and `line_start` are 0.
- Reset asserted mid-frame aborts immediately. After release, counting restarts at (0,0), and the first tick after release yields `frame_start`.

## Timing

- The first `tick` comes `CLK_DIV` clks after `rst` rises.
- Line period is `H_TOTAL`×`CLK_DIV` clks. Frame period is `H_TOTAL`×`V_TOTAL`×`CLK_DIV` clks. Defaults: 1600 clks per line and 840000 per frame.
- The sync/blank fields loaded on tick T describe the counter position at tick T-`PIX_LAT`.
- `r`/`g`/`b` sampled on tick T belong to the (`x`,`y`) presented `PIX_LAT` ticks earlier. All fields therefore change together, on the same clk edge.
- Output latency is 1 tick (register) plus `PIX_LAT` ticks from (`x`,`y`) to the DAC bus.
- Outputs hold steady between ticks.
- Simultaneous `h` and `v` wrap occurs at (`H_TOTAL`-1, `V_TOTAL`-1). The next tick is (0,0), with `frame_start` and `line_start` both pulsing.
- `pix_req` follows `x`/`y` with no added latency.

## Test plan

- **Reset values:** hold `rst`=0 with default parameters → bus = 0x0 on [23:0], [24]=1, [25]=1, [26]=0, [27]=1, [28]=0; `x`=`y`=0.
- **Default line timing:** run 2 lines → 1600 clks per line; hsync low for exactly 96 ticks starting when the output reflects h=656 (`PIX_LAT`+1 ticks after `x`=656); blank_n high for 640 ticks per line.
- **Frame and strobes:** run 2 frames → `frame_start` spacing exactly 840000 clks; vsync low for 2 lines starting at v=490; `line_start` count = 525 per frame.
- **Latency alignment:** `PIX_LAT`=2, source returns `r`=`x`[7:0] with a 2-tick delay → the first active output pixel has r=0 coincident with blank_n rising; r=0xFF at h=255; r forced to 0 during blanking.
- **Small geometry and polarity:** H=4/1/1/1, V=2/1/1/1, `HS_POL`=`VS_POL`=1, `CLK_DIV`=4 → `h` wraps every 7 ticks and `v` every 5 lines; hsync is high only at h=5; [28] is high 2 of every 4 clks.
- **Mid-frame reset:** assert `rst` at (x=300, y=200) for 3 clks → all outputs take their reset values immediately; after release, `frame_start` pulses on the first tick and (`x`,`y`) = (0,0).
